ir_prefetch_buf: RTL and testbench

- Parametrised successor to the instruction-register stage between fetch and decode.
- Registers the fetched instruction word for decode and holds it stable while decode stalls.
- Adds a DEPTH-entry FIFO so words arriving during a stall are kept, not lost.
- Adds valid/ready flow control toward fetch, a pipeline flush for branches and an occupancy count.

---
 rtl/ir_prefetch_buf.sv | 108 ++++++++++
 tb/tb_ir_prefetch_buf.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ir_prefetch_buf.sv
// Instruction prefetch buffer: output register in front of a DEPTH-entry FIFO, between fetch and decode.
// Define IR_BYPASS_EN to let a word skip an empty FIFO straight into the output register.
module ir_prefetch_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   i_valid,
  input  logic [WIDTH-1:0]       i_data,
  output logic                   i_ready,
  input  logic                   stall,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [CW-1:0]    level_reg, level_next;
  logic             o_valid_reg, o_valid_next;
  logic [WIDTH-1:0] o_data_reg;

  logic push, or_load, fifo_empty, bypass, pop, fifo_wr;

  // Ready depends only on the registered count, never on stall or i_valid.
  assign i_ready    = (count_reg != CW'(DEPTH));
  assign push       = i_valid && i_ready;
  assign or_load    = !o_valid_reg || !stall;
  assign fifo_empty = (count_reg == '0);

`ifdef IR_BYPASS_EN
  assign bypass = push && fifo_empty && or_load;
`else
  assign bypass = 1'b0;
`endif

  // FIFO head always has priority over the incoming word for the output register.
  assign pop     = or_load && !fifo_empty;
  assign fifo_wr = push && !bypass && !flush;

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    o_valid_next = o_valid_reg;
    if (flush) begin
      wr_ptr_next  = '0;
      rd_ptr_next  = '0;
      count_next   = '0;
      o_valid_next = 1'b0;
    end else begin
      if (fifo_wr) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      count_next = count_reg + {{AW{1'b0}}, fifo_wr} - {{AW{1'b0}}, pop};
      if (or_load) begin
        o_valid_next = pop || bypass;
      end
    end
    level_next = count_next + {{AW{1'b0}}, o_valid_next};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      level_reg   <= '0;
      o_valid_reg <= 1'b0;
      o_data_reg  <= '0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      level_reg   <= level_next;
      o_valid_reg <= o_valid_next;
      // o_data is left untouched by flush and whenever nothing loads.
      if (!flush) begin
        if (pop) begin
          o_data_reg <= mem[rd_ptr_reg];
        end else if (bypass) begin
          o_data_reg <= i_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem[wr_ptr_reg] <= i_data;
    end
  end

  assign o_valid = o_valid_reg;
  assign o_data  = o_data_reg;
  assign o_level = level_reg;

endmodule

// File: tb/tb_ir_prefetch_buf.sv
// Self-checking bench for ir_prefetch_buf against a queue-based model of the buffered words.
module tb_ir_prefetch_buf;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             i_valid = 1'b0;
  logic             stall = 1'b0;
  logic [WIDTH-1:0] i_data = '0;
  logic             i_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic [LW-1:0]    o_level;

  always #5 clk = ~clk;

  ir_prefetch_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .i_data(i_data),
    .i_ready(i_ready), .stall(stall), .o_valid(o_valid), .o_data(o_data), .o_level(o_level)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: q holds words not yet in the output register; m_ov/m_od is the word shown to decode.
  logic [WIDTH-1:0] q[$];
  logic             m_ov = 1'b0;
  logic [WIDTH-1:0] m_od = '0;
  logic             last_push = 1'b0;
  logic [WIDTH-1:0] next_word = '0;
  logic [WIDTH-1:0] hold_exp;
  logic             hold_chk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic fl, input logic iv, input logic st, input logic [WIDTH-1:0] d);
    logic push, may_load;
    push = iv && (q.size() != DEPTH);
    last_push = push;
    if (fl) begin
      q.delete();
      m_ov = 1'b0;
      return;
    end
    may_load = !m_ov || !st;
`ifdef IR_BYPASS_EN
    if (push) q.push_back(d);
    if (may_load) begin
      if (q.size() > 0) begin m_od = q.pop_front(); m_ov = 1'b1; end
      else m_ov = 1'b0;
    end
`else
    if (may_load) begin
      if (q.size() > 0) begin m_od = q.pop_front(); m_ov = 1'b1; end
      else m_ov = 1'b0;
    end
    if (push) q.push_back(d);
`endif
  endtask

  // One clock: latch the driven inputs, advance the model, compare every output after the edge.
  task automatic cycle();
    logic fl, iv, st;
    logic [WIDTH-1:0] d;
    fl = flush; iv = i_valid; st = stall; d = i_data;
    @(posedge clk);
    if (!rst) begin
      q.delete(); m_ov = 1'b0; m_od = '0; last_push = 1'b0;
    end else begin
      model_edge(fl, iv, st, d);
    end
    #1;
    check("o_valid", o_valid, m_ov);
    check("o_data", o_data, m_od);
    check("o_level", o_level, q.size() + m_ov);
    check("i_ready", i_ready, q.size() != DEPTH);
    if (last_push) begin
      next_word++;
      i_data = next_word;
    end
  endtask

  task automatic first_word_check(input string tag);
    cycle();
`ifdef IR_BYPASS_EN
    check({tag, "_valid"}, o_valid, 1);
    check({tag, "_data"}, o_data, 0);
`else
    check({tag, "_early"}, o_valid, 0);
    cycle();
    check({tag, "_valid"}, o_valid, 1);
    check({tag, "_data"}, o_data, 0);
`endif
  endtask

  initial begin
    // Reset
    cycle();
    cycle();
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_level", o_level, 0);
    check("rst_i_ready", i_ready, 1);
    rst = 1'b1;

    // Streaming 0,1,2,... until o_data reaches 5
    next_word = '0; i_data = '0; i_valid = 1'b1; stall = 1'b0;
    first_word_check("stream_first");
    for (int k = 0; k < 20 && !(o_valid && o_data == 5); k++) begin
      cycle();
      check("stream_level_le2", o_level <= 2, 1);
    end
    check("stream_reach5", o_data, 5);

    // Stall absorption
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("stall_hold5", o_data, 5);
    end
    check("stall_full_ready", i_ready, 0);
    check("stall_full_level", o_level, DEPTH + 1);

    // Full FIFO with one-cycle pop
    stall = 1'b0;
    cycle();
    check("fullpop_data", o_data, 6);
    check("fullpop_ready", i_ready, 1);
    stall = 1'b1;
    cycle();
    stall = 1'b0;
    for (int k = 0; k < 3 * DEPTH + 6; k++) cycle();

    // Flush with count=3, o_valid=1, i_valid=1
    stall = 1'b1; i_valid = 1'b1;
    for (int k = 0; k < 10 && !(q.size() == 3 && m_ov); k++) cycle();
    check("flush_pre_level", o_level, 4);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_o_valid", o_valid, 0);
    check("flush_o_level", o_level, 0);
    check("flush_i_ready", i_ready, 1);
    next_word = 16'h00AA; i_data = 16'h00AA; stall = 1'b0;
    cycle();
    i_valid = 1'b0;
    for (int k = 0; k < 4 && !o_valid; k++) cycle();
    check("flush_next_word", o_data, 16'h00AA);

    // Asynchronous reset mid-operation with FIFO count=2
    stall = 1'b1; i_valid = 1'b1;
    for (int k = 0; k < 10 && q.size() != 2; k++) cycle();
    check("arst_pre_level", o_level, 3);
    i_valid = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check("arst_o_valid", o_valid, 0);
    check("arst_o_data", o_data, 0);
    check("arst_o_level", o_level, 0);
    check("arst_i_ready", i_ready, 1);
    cycle();
    rst = 1'b1;
    next_word = '0; i_data = '0; i_valid = 1'b1; stall = 1'b0;
    first_word_check("resume_first");
    for (int k = 0; k < 6; k++) cycle();

    // Random stall / i_valid / occasional flush
    for (int k = 0; k < 10000; k++) begin
      stall   = $urandom_range(0, 1);
      i_valid = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 63) == 0);
      i_data  = WIDTH'($urandom);
      hold_chk = m_ov && stall && !flush;
      hold_exp = m_od;
      cycle();
      if (hold_chk) begin
        check("rand_hold_valid", o_valid, 1);
        check("rand_hold_data", o_data, hold_exp);
      end
    end
    flush = 1'b0; i_valid = 1'b0; stall = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
